// File: rtl/max_unpooling.sv
// 2x nearest-neighbour unpooling with a ping-pong row buffer.
// Define UNPOOL_ZERO_FILL_EN for sparse (bottom-right only) output.
module max_unpooling #(
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 240,
  parameter int W_WIDTH    = 512,
  parameter int W_HEIGHT   = 256,
  parameter int FIXED_BITW = 16,
  parameter int UNITS      = 8,
  parameter int LEVEL      = 0
) (
  input  logic                            clock,
  input  logic                            n_rst,
  input  logic                            in_enable,
  input  logic [FIXED_BITW*UNITS-1:0]     in_pixels,
  input  logic [$clog2(W_HEIGHT)-1:0]     in_vcnt,
  input  logic [$clog2(W_WIDTH)-1:0]      in_hcnt,
  output logic                            out_enable,
  output logic [FIXED_BITW*UNITS-1:0]     out_pixels,
  output logic [$clog2(W_HEIGHT)-1:0]     out_vcnt,
  output logic [$clog2(W_WIDTH)-1:0]      out_hcnt
);

  localparam int S    = 1 << (LEVEL + 1);
  localparam int DW   = FIXED_BITW * UNITS;
  localparam int VW   = $clog2(W_HEIGHT);
  localparam int HW   = $clog2(W_WIDTH);
  localparam int COLS = W_WIDTH / S;
  localparam int CW   = HW - LEVEL - 1;

  localparam logic [HW-1:0] HMASK = HW'((1 << LEVEL) - 1);
  localparam logic [VW-1:0] VMASK = VW'((1 << LEVEL) - 1);
  localparam logic [HW-1:0] HLAST = HW'(W_WIDTH - 1);

  if (WIDTH > W_WIDTH || HEIGHT > W_HEIGHT) begin : g_bad_size
    $error("active area exceeds frame size");
  end

  logic [DW-1:0] mem [2*COLS];
  logic [DW-1:0] rd_data;
  logic [CW-1:0] col;
  logic          wr_bank;
  logic          primed;
  logic          row_done;

  logic [HW-1:0] h1;
  logic [VW-1:0] v1;
  logic          p1;
  logic [VW:0]   vsum;
  logic [VW-1:0] vprev;
  logic          hit;
  logic [DW-1:0] val;

  assign col      = in_hcnt[HW-1 -: CW];
  assign row_done = in_enable && (in_hcnt == HLAST);

  // RAM: write bank and read bank always differ
  always_ff @(posedge clock) begin
    if (in_enable) mem[{wr_bank, col}] <= in_pixels;
    rd_data <= mem[{~wr_bank, col}];
  end

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      wr_bank <= 1'b0;
      primed  <= 1'b0;
    end else if (row_done) begin
      wr_bank <= ~wr_bank;
      primed  <= 1'b1;
    end
  end

  // Output line is one block row behind the input line
  always_comb begin
    vsum  = {1'b0, in_vcnt} + (VW+1)'(W_HEIGHT - S);
    vprev = vsum[VW-1:0];
    if (vsum >= (VW+1)'(W_HEIGHT))
      vprev = VW'(vsum - (VW+1)'(W_HEIGHT));
  end

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      h1 <= '0;
      v1 <= '0;
      p1 <= 1'b0;
    end else begin
      h1 <= in_hcnt;
      v1 <= vprev;
      p1 <= primed;
    end
  end

  assign hit = p1 && ((h1 & HMASK) == HMASK)
                  && ((v1 & VMASK) == VMASK);

`ifdef UNPOOL_ZERO_FILL_EN
  assign val = (h1[LEVEL] && v1[LEVEL]) ? rd_data : '0;
`else
  assign val = rd_data;
`endif

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      out_enable <= 1'b0;
      out_pixels <= '0;
      out_vcnt   <= '0;
      out_hcnt   <= '0;
    end else begin
      out_enable <= hit;
      out_hcnt   <= h1;
      out_vcnt   <= v1;
      if (hit) out_pixels <= val;
    end
  end

endmodule

// File: tb/tb_max_unpooling.sv
// Bench for max_unpooling: 16x8 frame, LEVEL 0, one 8-bit channel.
// Model tracks bank contents; compare process checks every cycle.
module tb_max_unpooling;

  localparam int WW = 16;
  localparam int WH = 8;
  localparam int LV = 0;
  localparam int S  = 2;
  localparam int NC = 164;

  logic       clock;
  logic       n_rst;
  logic       in_enable;
  logic [7:0] in_pixels;
  logic [2:0] in_vcnt;
  logic [3:0] in_hcnt;
  logic       out_enable;
  logic [7:0] out_pixels;
  logic [2:0] out_vcnt;
  logic [3:0] out_hcnt;

  max_unpooling #(
    .WIDTH(WW), .HEIGHT(WH), .W_WIDTH(WW), .W_HEIGHT(WH),
    .FIXED_BITW(8), .UNITS(1), .LEVEL(LV)
  ) dut (
    .clock(clock), .n_rst(n_rst),
    .in_enable(in_enable), .in_pixels(in_pixels),
    .in_vcnt(in_vcnt), .in_hcnt(in_hcnt),
    .out_enable(out_enable), .out_pixels(out_pixels),
    .out_vcnt(out_vcnt), .out_hcnt(out_hcnt)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cur   = -1;
  int exp_en [NC];
  int exp_px [NC];
  int exp_h  [NC];
  int exp_v  [NC];
  bit exp_rs [NC];

  int mm [2][WW/S];
  int wb_m, primed_m, last_m;

  always #5 clock = ~clock;

  task automatic chk(string nm, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cur, act, req);
    end
  endtask

  function automatic int lit(int val, int h, int v);
`ifdef UNPOOL_ZERO_FILL_EN
    return (h % 2 == 1 && v % 2 == 1) ? val : 0;
`else
    return val + 0 * (h + v);
`endif
  endfunction

  task automatic lit_chk(int px, int h, int v, int en);
    chk("lit_en", int'(out_enable), en);
    chk("lit_px", int'(out_pixels), en ? lit(px, h, v) : px);
    chk("lit_h", int'(out_hcnt), h);
    chk("lit_v", int'(out_vcnt), v);
  endtask

  always @(negedge clock) begin
    if (cur >= 2) begin
      if (!n_rst || exp_rs[cur-2]) begin
        chk("rst_en", int'(out_enable), 0);
        chk("rst_px", int'(out_pixels), 0);
        chk("rst_h", int'(out_hcnt), 0);
        chk("rst_v", int'(out_vcnt), 0);
      end else begin
        chk("en", int'(out_enable), exp_en[cur-2]);
        chk("px", int'(out_pixels), exp_px[cur-2]);
        chk("h", int'(out_hcnt), exp_h[cur-2]);
        chk("v", int'(out_vcnt), exp_v[cur-2]);
      end
      case (cur)
        22:  lit_chk(0, 4, 7, 0);
        34:  lit_chk(10, 0, 0, 1);
        37:  lit_chk(11, 3, 0, 1);
        49:  lit_chk(17, 15, 0, 1);
        51:  lit_chk(10, 1, 1, 1);
        65:  lit_chk(17, 15, 1, 1);
        67:  lit_chk(20, 1, 2, 1);
        80:  lit_chk(0, 14, 2, 0);
        92:  lit_chk(0, 10, 3, 0);
        102: lit_chk(8'hFB, 4, 4, 1);
        119: lit_chk(8'hFB, 5, 5, 1);
        130: lit_chk(40, 0, 6, 1);
        default: ;
      endcase
    end
  end

  initial begin
    int pos, h, v, k, vp, val, en, px, ie;
    clock = 0;
    n_rst = 0;
    in_enable = 0;
    in_pixels = 0;
    in_vcnt = 0;
    in_hcnt = 0;
    wb_m = 0;
    primed_m = 0;
    last_m = 0;
    for (int b = 0; b < 2; b++)
      for (int c = 0; c < WW/S; c++) mm[b][c] = 0;
    for (int n = 0; n < NC; n++) begin
      @(posedge clock);
      #2;
      pos = n % (WW * WH);
      v = pos / WW;
      h = pos % WW;
      k = h / 2;
      ie = (n < WW * WH) && (v % 2 == 1) && (h % 2 == 1);
      case (v)
        1: px = 10 + k;
        3: px = 20 + k;
        5: px = (k == 2) ? 8'hFB : 30 + k;
        7: px = 40 + k;
        default: px = 8'hAA;
      endcase
      n_rst = !(n < 2 || (n >= 70 && n < 73));
      in_enable = ie[0];
      in_pixels = px[7:0];
      in_vcnt = v[2:0];
      in_hcnt = h[3:0];
      if (!n_rst) begin
        primed_m = 0;
        wb_m = 0;
        last_m = 0;
        exp_rs[n] = 1;
        exp_en[n] = 0;
        exp_px[n] = 0;
        exp_h[n] = 0;
        exp_v[n] = 0;
      end else begin
        vp = (v + WH - S) % WH;
        en = primed_m != 0
          && (h % (1 << LV)) == (1 << LV) - 1
          && (vp % (1 << LV)) == (1 << LV) - 1;
        if (en != 0) begin
          val = mm[1-wb_m][h/S];
`ifdef UNPOOL_ZERO_FILL_EN
          if (!(((h >> LV) & 1) == 1 && ((vp >> LV) & 1) == 1)) val = 0;
`endif
          last_m = val;
        end
        exp_rs[n] = 0;
        exp_en[n] = en;
        exp_px[n] = last_m;
        exp_h[n] = h;
        exp_v[n] = vp;
        if (ie != 0) begin
          mm[wb_m][h/S] = px;
          if (h == WW - 1) begin
            wb_m = 1 - wb_m;
            primed_m = 1;
          end
        end
      end
      cur = n;
    end
    @(posedge clock);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/max_unpooling.md
Name: max_unpooling

Overview:
- 2x nearest-neighbour unpooling (upsampling) layer for the decoder half of the stream CNN; the counterpart of the 2x2 max-pooling layer.
- Consumes the sparse pooled stream: full-rate frame counters, with `in_enable` high only on pooled sample positions.
- Replicates each pooled value over its 2x2 block on the next-finer grid.
- Uses a ping-pong row buffer. Output is a full-rate stream delayed by one block row, with `out_enable` marking finer-grid positions.

Parameters:
- WIDTH, 320, active image width (informational; must be <= W_WIDTH)
- HEIGHT, 240, active image height (informational; must be <= W_HEIGHT)
- W_WIDTH, 512, frame width incl. blanking; must be a multiple of 2^(LEVEL+1)
- W_HEIGHT, 256, frame height incl. blanking; must be >= 2*2^(LEVEL+1)
- FIXED_BITW, 16, bits per signed fixed-point channel value
- UNITS, 8, channels per pixel
- LEVEL, 0, pooling level of the input; S = 2^(LEVEL+1) is the block span in pixels and lines

Ports:
- clock  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- in_enable  in  1  pooled sample valid; expected only where in_hcnt[LEVEL:0] and in_vcnt[LEVEL:0] are all ones
- in_pixels  in  FIXED_BITW*UNITS  pooled channels, channel 0 at MSB end
- in_vcnt  in  log2(W_HEIGHT)  frame line counter, advances every cycle with hcnt
- in_hcnt  in  log2(W_WIDTH)  frame pixel counter
- out_enable  out  1  finer-grid sample valid
- out_pixels  out  FIXED_BITW*UNITS  upsampled channels
- out_vcnt  out  log2(W_HEIGHT)  output line coordinate
- out_hcnt  out  log2(W_WIDTH)  output pixel coordinate

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low.
- Reset values: all outputs 0; `primed`=0; `wr_bank`=0. Buffer RAM is not reset.
- Storage: two banks of W_WIDTH/S words, each FIXED_BITW*UNITS wide. Column address = hcnt >> (LEVEL+1).
- Write path: when in_enable=1, store in_pixels into bank `wr_bank` at col(in_hcnt). If in_hcnt == W_WIDTH-1 on that write, toggle `wr_bank` and set `primed`=1.
- Read path, cycle t: address col(in_hcnt(t)) in bank ~wr_bank. If the same cycle toggles `wr_bank`, this read still uses the pre-toggle value.
- Read path, cycle t+1: RAM data registered.
- Read path, cycle t+2: registered outputs.
- Latency: 2 cycles.
  - out_hcnt(t+2) = in_hcnt(t).
  - out_vcnt(t+2) = (in_vcnt(t) + W_HEIGHT - S) mod W_HEIGHT, i.e. the previous block row.
- Pixel value: out_pixels = word read, the same value for all S x S positions of a block.
- Enable: out_enable = primed && low LEVEL bits of out_hcnt and out_vcnt are all ones. For LEVEL=0 this means every pixel.
- When out_enable=0, out_pixels holds its last enabled value.
- Bank usage: a write never targets the bank being read, so no read/write collision exists.
- Signedness: pure bit copy; no arithmetic and no width change.
- Frame wrap: the first S lines of a frame output the last block row of the previous frame (out_vcnt wraps to W_HEIGHT-S..W_HEIGHT-1).
- Before `primed`, out_enable=0 and out_pixels=0.
- in_enable at a non-grid position: the value is written anyway (last write wins). No error flag.
- Reset mid-frame: outputs cleared immediately; `primed` cleared. Stale RAM is never exposed, because `primed` requires a completed row.

Optional Feature:
- Macro: UNPOOL_ZERO_FILL_EN.
- Defined (sparse SegNet-style unpooling): out_pixels = buffered value only at the block's bottom-right finer position, i.e. bit LEVEL of out_hcnt and out_vcnt both 1. Other enabled positions output all zeros.
- Undefined: replication as specified above.

Test Plan:
Common bench parameters: W_WIDTH=16, W_HEIGHT=8, LEVEL=0, UNITS=1, FIXED_BITW=8, so S=2.
- Reset, then frame 0 lines 0-1 with no enable -> out_enable=0 and out_pixels=0 for the whole span.
- Line 1: in_enable at h=1,3,...,15 with values 10..17 -> during input lines 2-3, out_vcnt=0/1; out_hcnt 0,1 give 10; 2,3 give 11; 14,15 give 17; out_enable=1.
- Line 3: write 20..27 while row 0 is replayed -> output at input (3,15) is still 17, not 27. Lines 4-5 replay 20..27.
- Write value 0xFB (-5) -> replicated bit-exact 0xFB at all four positions.
- Assert n_rst low mid-line 4 for 3 cycles, then release -> out_enable=0 until the next completed row write at h=15.
- With UNPOOL_ZERO_FILL_EN and the same stimulus as line 1 -> out(1,1)=10, out(0,0)=out(0,1)=out(1,0)=0.
